lut_k_array_cfg: RTL
====================

// Module: lut_k_array_cfg
// PURPOSE
//  Array of N_LUT programmable K-input lookup tables with a clocked serial configuration port.
//  Config loads into a shadow table and commits atomically, so outputs never see a half-written table.
//  The port supports stall, restart and a shift-out for daisy-chaining and readback.
//  Sits between the pin muxing (ui_in/uio_in) and the output drivers of the LUT tile.
// PARAMETERS
//  K        4  LUT input count; each table holds 2**K bits
//  N_LUT    2  number of independent LUTs
//  REG_OUT  1  1: registered outputs (1-cycle latency); 0: combinational lookup
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  ena        in   1          1: block active; 0: FSM, shadow and output flops hold
//  cfg_start  in   1          pulse: begin/restart a config load
//  cfg_valid  in   1          cfg_bit valid this cycle
//  cfg_bit    in   1          serial config data, table bit 0 first
//  cfg_ready  out  1          load accepting bits (state LOAD)
//  cfg_done   out  1          1-cycle pulse: new table committed
//  cfg_dout   out  1          shadow[0], previous shadow content shifted out
//  lut_in     in   N_LUT*K    LUT j address = lut_in[j*K +: K]
//  lut_out    out  N_LUT      lut_out[j] = active[j*2**K + addr_j]
// BEHAVIOUR
//  W = N_LUT*2**K config bits. CW = $clog2(W) counter width.
//  Reset (async, rst_n=0): state=IDLE, shadow=0, active=0, bit_cnt=0.
//   Outputs: cfg_ready=0, cfg_done=0, cfg_dout=0, lut_out=0.
//  FSM, all transitions gated by ena=1:
//   IDLE:   cfg_start -> LOAD, bit_cnt=0. cfg_valid is ignored.
//   LOAD:   cfg_ready=1.
//           Accept when cfg_valid&cfg_ready: shadow <= {cfg_bit, shadow[W-1:1]}, bit_cnt++.
//           After W accepts, bit i of the stream is in shadow[i].
//           Accept with bit_cnt==W-1 -> COMMIT.
//           cfg_start in LOAD -> bit_cnt=0, stay in LOAD; a bit accepted in the same cycle is discarded.
//   COMMIT: active <= shadow, cfg_done=1 for this cycle only, -> IDLE. cfg_start here is ignored.
//  Stall: cfg_valid=0 or ena=0 holds bit_cnt and shadow; there is no timeout.
//  cfg_dout = shadow[0] combinationally. It changes only on accepts.
//  Lookup:
//   REG_OUT=1: lut_out registered from active and lut_in; latency 1 cycle.
//     The flop sampled in the COMMIT cycle uses the old table; the new table is visible 1 cycle later.
//   REG_OUT=0: lut_out reflects active immediately; it switches on the clock edge ending COMMIT.
//  Reset asserted mid-load: everything returns to reset values and the partial load is lost.
//  The active table never changes except in COMMIT.
// STRUCTURE
//  lut_cfg_pkg:
//   state enum {IDLE, LOAD, COMMIT} (2-bit).
//   Functions cfg_width(K,N_LUT) and cnt_width.
//  Sub-module lut_cfg_loader:
//   Contains the FSM, bit counter and shadow shift register.
//   Outputs shadow[W-1:0], commit, cfg_ready, cfg_done.
//  Top level: active register, per-LUT mux, optional output flops.
// TESTING (K=4, N_LUT=2, REG_OUT=1, W=32)
//  1. Reset:
//     rst_n=0, then release -> lut_out=2'b00, cfg_ready=0, cfg_done=0 for every lut_in.
//  2. Load 32'h6996_8000 (LUT0=AND4, LUT1=XOR4), LSB first, cfg_valid always 1:
//     -> cfg_done exactly 1 cycle after the 32nd accept.
//     -> Then lut_in=8'h1F gives lut_out=2'b11 and lut_in=8'hFF gives 2'b01, each 1 cycle after lut_in.
//  3. Atomic swap:
//     Load 32'hFFFF_0000 while lut_in=8'h1F -> lut_out stays 2'b11 through LOAD and becomes 2'b10 2 cycles after the COMMIT cycle.
//     cfg_dout emits 0,0,...,0 (15x), 1, then 6996 bits LSB first.
//  4. Restart and stall:
//     10 bits, then cfg_start, then 32 bits with cfg_valid toggling 1/0 and ena low for 3 cycles.
//     -> bit_cnt holds during gaps; cfg_done only after the 32nd post-restart accept.
//     -> The table equals the post-restart stream only.
//  5. Reset mid-load:
//     Table 32'h6996_8000 active, start a new load, assert rst_n at bit 20.
//     -> lut_out=2'b00, state IDLE, cfg_ready=0, and the next cfg_valid is ignored.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration tile.
// Provides the loader state enum and config/counter width functions.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic int cfg_width(
    input int k,
    input int n
  );
    return n * (1 << k);
  endfunction

  function automatic int cnt_width(
    input int w
  );
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial config loader: FSM, bit counter and shadow shift register.
// Ports: clk, rst_n, ena, cfg_start/valid/bit in; cfg_ready, cfg_done, commit, shadow out.
import lut_cfg_pkg::*;

module lut_cfg_loader #(
  parameter int W  = 32,
  parameter int CW = cnt_width(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         commit,
  output logic [W-1:0] shadow
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  cfg_state_e    state;
  cfg_state_e    state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [W-1:0]  shadow_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shadow  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      shadow  <= shadow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = bit_cnt;
    shadow_nxt = shadow;
    cfg_ready  = 1'b0;
    cfg_done   = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ena && cfg_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (ena) begin
          // restart wins over a bit offered in the same cycle
          if (cfg_start) begin
            cnt_nxt = '0;
          end else if (cfg_valid) begin
            shadow_nxt = {cfg_bit, shadow[W-1:1]};
            if (bit_cnt == LAST) begin
              cnt_nxt   = '0;
              state_nxt = COMMIT;
            end else begin
              cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
      end
      COMMIT: begin
        if (ena) begin
          commit    = 1'b1;
          cfg_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/lut_k_array_cfg.sv
// Array of N_LUT K-input LUTs with atomically committed serial config.
// Ports: clk, rst_n, ena, cfg_* serial port, lut_in address bus, lut_out.
import lut_cfg_pkg::*;

module lut_k_array_cfg #(
  parameter int K       = 4,
  parameter int N_LUT   = 2,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_dout,
  input  logic [N_LUT*K-1:0] lut_in,
  output logic [N_LUT-1:0] lut_out
);

  localparam int TBL = 1 << K;
  localparam int W   = cfg_width(K, N_LUT);

  logic [W-1:0]     shadow;
  logic [W-1:0]     active;
  logic             commit;
  logic [N_LUT-1:0] lut_nxt;

  lut_cfg_loader #(
    .W (W)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .commit    (commit),
    .shadow    (shadow)
  );

  assign cfg_dout = shadow[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow;
    end
  end

  always_comb begin
    lut_nxt = '0;
    for (int j = 0; j < N_LUT; j++) begin
      logic [TBL-1:0] tbl;
      logic [K-1:0]   addr;
      tbl        = active[j*TBL +: TBL];
      addr       = lut_in[j*K +: K];
      lut_nxt[j] = tbl[addr];
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [N_LUT-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else if (ena) begin
          out_q <= lut_nxt;
        end
      end
      assign lut_out = out_q;
    end else begin : g_comb
      assign lut_out = lut_nxt;
    end
  endgenerate

endmodule
